// File: rtl/seg_bcd_counter_mux.sv
// ---------------------------------------------------------------------------
// seg_bcd_counter_mux
//   Multi-digit BCD event counter with a time-multiplexed 7-segment driver.
//   Each rising edge of count_ack seen while count_en is high adds one to a
//   NUM_DIGITS-digit BCD count. The count either wraps or saturates at all
//   nines. The digits are scanned one at a time onto a shared segment bus.
//
// Parameters
//   NUM_DIGITS  number of BCD digits (1..8), digit 0 is least significant
//   SCAN_DIV    clock cycles each digit is driven before moving on (>=1)
//   WRAP        1: all nines + 1 gives 0, 0: saturate at all nines
//
// Ports
//   clk        system clock, rising edge
//   RESET      asynchronous active-high reset
//   count_en   counting enable, ack edges are ignored while low
//   count_ack  event line, each 0->1 transition is one event
//   clear      synchronous clear of the count (wins over an increment)
//   seg_out    {g,f,e,d,c,b,a} of the digit being driven, 1 = lit
//   digit_sel  one-hot digit select, bit i = digit i driven
//   count_bcd  current count, digit i at [4i+3:4i]
//   at_max     high while the count is all nines
//   overflow   one-cycle pulse when an increment is attempted at all nines
//
// Optional feature
//   SEG_LEADING_ZERO_BLANK_EN: when defined, leading zero digits above digit
//   0 are blanked (seg_out = 0). digit_sel keeps scanning as usual.
// ---------------------------------------------------------------------------
module seg_bcd_counter_mux #(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 1000,
  parameter bit WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    count_en,
  input  logic                    count_ack,
  input  logic                    clear,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    at_max,
  output logic                    overflow
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0]       SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic                    ack_q;
  logic [4*NUM_DIGITS-1:0] count_q, count_d, count_inc;
  logic                    overflow_q, overflow_d;
  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [6:0]              seg_q, seg_d;
  logic                    inc;
  logic                    carry;
  logic [3:0]              shown_nib;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // One event per rising edge of count_ack, qualified by count_en on that same edge.
  assign inc    = count_en & count_ack & ~ack_q;
  assign at_max = (count_q == ALL_NINES);

  // BCD +1 with the carry rippling through every digit in a single cycle.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'h9) begin
          count_inc[4*i +: 4] = 4'h0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'h1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Clear has priority, then increment, otherwise hold.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      if (at_max) begin
        overflow_d = 1'b1;
        if (WRAP) count_d = '0;
      end else begin
        count_d = count_inc;
      end
    end
  end

  // Scan timer: stay SCAN_DIV cycles on a digit, then advance with wrap.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end
  end

  // Pick the digit being scanned and decode it. Select and segments are
  // registered together so they always change on the same edge.
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  higher_zero;
  logic                  shown_blank;

  // A digit above digit 0 is blank when it and every higher digit are zero.
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (count_q[4*i +: 4] == 4'h0);
      if (i > 0) blank[i] = higher_zero;
    end
  end
`endif

  always_comb begin
    shown_nib = 4'h0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    shown_blank = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        shown_nib = count_q[4*i +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        shown_blank = blank[i];
`endif
      end
    end
    seg_d = decode(shown_nib);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (shown_blank) seg_d = 7'h00;
`endif
    digit_sel_d = NUM_DIGITS'(1) << digit_idx_q;
  end

  // All state registers; reset aborts any count or scan in progress.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ack_q       <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      digit_sel_q <= NUM_DIGITS'(1);
      seg_q       <= 7'h3F;
    end else begin
      ack_q       <= count_ack;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign overflow  = overflow_q;
  assign digit_sel = digit_sel_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_seg_bcd_counter_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_bcd_counter_mux
//   Three instances share clock, reset, ack and clear; each has its own
//   enable so they can be steered to different counts:
//     A: 2 digits, SCAN_DIV=4, wrap
//     B: 2 digits, SCAN_DIV=1, saturate
//     C: 3 digits, SCAN_DIV=1, wrap
// ---------------------------------------------------------------------------
module tb_seg_bcd_counter_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET;
  logic       ack;
  logic       clear;
  logic [2:0] en;

  logic [6:0]  segA, segB, segC;
  logic [1:0]  selA, selB;
  logic [2:0]  selC;
  logic [7:0]  cntA, cntB;
  logic [11:0] cntC;
  logic        maxA, maxB, maxC;
  logic        ovfA, ovfB, ovfC;

  seg_bcd_counter_mux #(.NUM_DIGITS(2), .SCAN_DIV(4), .WRAP(1'b1)) dutA (
    .clk(clk), .RESET(RESET), .count_en(en[0]), .count_ack(ack), .clear(clear),
    .seg_out(segA), .digit_sel(selA), .count_bcd(cntA), .at_max(maxA), .overflow(ovfA));

  seg_bcd_counter_mux #(.NUM_DIGITS(2), .SCAN_DIV(1), .WRAP(1'b0)) dutB (
    .clk(clk), .RESET(RESET), .count_en(en[1]), .count_ack(ack), .clear(clear),
    .seg_out(segB), .digit_sel(selB), .count_bcd(cntB), .at_max(maxB), .overflow(ovfB));

  seg_bcd_counter_mux #(.NUM_DIGITS(3), .SCAN_DIV(1), .WRAP(1'b1)) dutC (
    .clk(clk), .RESET(RESET), .count_en(en[2]), .count_ack(ack), .clear(clear),
    .seg_out(segC), .digit_sel(selC), .count_bcd(cntC), .at_max(maxC), .overflow(ovfC));

  typedef struct {
    logic        rst;
    logic [2:0]  en;
    int          pulses;
    int          hi;
    int          lo;
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [11:0] expC;
    int          tag;
  } vec_t;

  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold reset for two cycles with all inputs idle; release on a falling edge.
  task automatic doReset();
    en    = 3'b000;
    ack   = 1'b0;
    clear = 1'b0;
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
  endtask

  // Drive n ack pulses, hi cycles high and lo cycles low each.
  task automatic applyStimulus(input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      ack = 1'b1;
      repeat (hi) @(negedge clk);
      ack = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " cntA"}, cntA, 0);
    checkOutput({tag, " cntB"}, cntB, 0);
    checkOutput({tag, " cntC"}, cntC, 0);
    checkOutput({tag, " selA"}, selA, 2'b01);
    checkOutput({tag, " selC"}, selC, 3'b001);
    checkOutput({tag, " segA"}, segA, 7'h3F);
    checkOutput({tag, " segC"}, segC, 7'h3F);
    checkOutput({tag, " maxA"}, maxA, 0);
    checkOutput({tag, " ovfA"}, ovfA, 0);
  endtask

  // Watch C scan for six cycles; every digit must appear with its pattern.
  task automatic scanC(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [2:0] seen;
    seen = 3'b000;
    for (int j = 0; j < 6; j++) begin
      case (selC)
        3'b001:  begin checkOutput("scanC d0", segC, e0); seen[0] = 1'b1; end
        3'b010:  begin checkOutput("scanC d1", segC, e1); seen[1] = 1'b1; end
        3'b100:  begin checkOutput("scanC d2", segC, e2); seen[2] = 1'b1; end
        default: checkOutput("scanC onehot", selC, 3'b001);
      endcase
      @(negedge clk);
    end
    checkOutput("scanC coverage", seen, 3'b111);
  endtask

  // With count 37 on A, the select must hold 4 cycles per digit.
  task automatic scanA();
    logic [1:0] prev, s0, expSel;
    int waited;
    prev   = selA;
    waited = 0;
    while (selA == prev && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (selA == prev) checkOutput("scanA advance timeout", selA, ~prev);
    s0 = selA;
    for (int j = 0; j < 12; j++) begin
      expSel = (((j / 4) % 2) == 0) ? s0 : ~s0;
      checkOutput("scanA sel", selA, expSel);
      checkOutput("scanA seg", segA, (expSel == 2'b01) ? 7'h07 : 7'h4F);
      @(negedge clk);
    end
  endtask

  // Reset asserted between edges must clear outputs without waiting for clk.
  task automatic midReset();
    #2 RESET = 1'b1;
    #1;
    checkOutput("async cntA", cntA, 0);
    checkOutput("async selA", selA, 2'b01);
    checkOutput("async segA", segA, 7'h3F);
    checkOutput("async cntC", cntC, 0);
    @(negedge clk);
    RESET = 1'b0;
  endtask

  // One more pulse with A and B at 99: A wraps, B holds; both flag overflow once.
  task automatic wrapSat();
    int nA, nB;
    nA  = 0;
    nB  = 0;
    ack = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (ovfA) nA++;
      if (ovfB) nB++;
      if (j == 0) ack = 1'b0;
    end
    checkOutput("wrap ovfA pulses", nA, 1);
    checkOutput("sat ovfB pulses", nB, 1);
    checkOutput("wrap cntA", cntA, 8'h00);
    checkOutput("sat cntB", cntB, 8'h99);
    checkOutput("wrap maxA", maxA, 0);
    checkOutput("sat maxB", maxB, 1);
  endtask

  // Clear and an increment edge together at 42: clear wins, no overflow.
  task automatic clearVsInc();
    int n;
    n     = 0;
    clear = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    if (ovfA) n++;
    clear = 1'b0;
    ack   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ovfA) n++;
    end
    checkOutput("clear cntA", cntA, 8'h00);
    checkOutput("clear ovfA", n, 0);
  endtask

  initial begin
    RESET = 1'b1;
    vecs[0] = '{1'b0, 3'b111,   5,  4, 4, 8'h05, 8'h05, 12'h005, 1};
    vecs[1] = '{1'b0, 3'b001,  10,  4, 4, 8'h10, 8'h00, 12'h000, 0};
    vecs[2] = '{1'b0, 3'b001,   1, 20, 4, 8'h11, 8'h00, 12'h000, 0};
    vecs[3] = '{1'b0, 3'b000,   3,  2, 2, 8'h11, 8'h00, 12'h000, 0};
    vecs[4] = '{1'b0, 3'b001,   7,  1, 1, 8'h18, 8'h00, 12'h000, 0};
    vecs[5] = '{1'b0, 3'b001,  19,  2, 2, 8'h37, 8'h00, 12'h000, 2};
    vecs[6] = '{1'b1, 3'b011,  99,  1, 1, 8'h99, 8'h99, 12'h000, 3};
    vecs[7] = '{1'b1, 3'b001,  42,  1, 1, 8'h42, 8'h00, 12'h000, 4};
    vecs[8] = '{1'b1, 3'b100, 100,  1, 1, 8'h00, 8'h00, 12'h100, 5};
    vecs[9] = '{1'b0, 3'b110,   1,  1, 1, 8'h00, 8'h01, 12'h101, 0};

    doReset();
    checkResetState("reset");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) doReset();
      en = vecs[i].en;
      applyStimulus(vecs[i].pulses, vecs[i].hi, vecs[i].lo);
      checkOutput($sformatf("v%0d cntA", i), cntA, vecs[i].expA);
      checkOutput($sformatf("v%0d cntB", i), cntB, vecs[i].expB);
      checkOutput($sformatf("v%0d cntC", i), cntC, vecs[i].expC);
      checkOutput($sformatf("v%0d maxA", i), maxA, vecs[i].expA == 8'h99);
      checkOutput($sformatf("v%0d maxB", i), maxB, vecs[i].expB == 8'h99);
      checkOutput($sformatf("v%0d ovfA", i), ovfA, 0);
      case (vecs[i].tag)
        1: begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
          scanC(7'h6D, 7'h00, 7'h00);
`else
          scanC(7'h6D, 7'h3F, 7'h3F);
`endif
          midReset();
        end
        2: scanA();
        3: wrapSat();
        4: clearVsInc();
        5: scanC(7'h3F, 7'h3F, 7'h06);
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
